// File: rtl/afe_spi_pkg.sv
// Shared types for the AFE attenuator serial controller: FSM state encoding and serial half-period sizing.
package afe_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    LE_SETUP,
    LE_HIGH,
    GAP
  } spi_state_t;

  // Smallest whole number of sysClk cycles per half serial period that keeps SPI clock at or below its limit.
  function automatic int calc_half_period(input longint clk_rate, input longint spi_clk_rate);
    longint hp;
    hp = (clk_rate + 2 * spi_clk_rate - 1) / (2 * spi_clk_rate);
    return (hp < 1) ? 1 : int'(hp);
  endfunction

endpackage

// File: rtl/afe_spi_tick.sv
// Half-period divider: tick pulses every HALF_PERIOD cycles while run is high, clear restarts the count;
// skip makes the interval after the current tick one cycle shorter. No backpressure.
module afe_spi_tick import afe_spi_pkg::*; #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  input  logic skip,
  output logic tick
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] LAST     = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] SKIP_VAL = (HALF_PERIOD > 1) ? CW'(1) : '0;

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      if (cnt == LAST) cnt <= skip ? SKIP_VAL : '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/afe_spi_ctrl.sv
// AFE attenuator serial writer: one {channel,data} command shifted MSB-first then LE-latched; cmdReady returns
// (2*DATA_WIDTH+4)*HALF_PERIOD cycles after accept, commands ignored while busy. `AFE_SPI_SHADOW_EN adds shadowData.
module afe_spi_ctrl import afe_spi_pkg::*; #(
  parameter int CLK_RATE      = 99999001,
  parameter int SPI_CLK_RATE  = 12500000,
  parameter int DATA_WIDTH    = 8,
  parameter int CHANNEL_COUNT = 2,
  localparam int CH_W = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
  input  logic                     sysClk,
  input  logic                     sysReset,
  input  logic                     cmdValid,
  output logic                     cmdReady,
  input  logic [CH_W-1:0]          cmdChannel,
  input  logic [DATA_WIDTH-1:0]    cmdData,
  output logic                     doneStrobe,
  output logic                     badChannel,
  output logic [CHANNEL_COUNT-1:0] AFE_SPI_CLK,
  output logic [CHANNEL_COUNT-1:0] AFE_SPI_SDI,
  output logic [CHANNEL_COUNT-1:0] AFE_SPI_LE
`ifdef AFE_SPI_SHADOW_EN
  ,
  output logic [CHANNEL_COUNT*DATA_WIDTH-1:0] shadowData
`endif
);

  localparam int HALF_PERIOD = calc_half_period(CLK_RATE, SPI_CLK_RATE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] TOP_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [CHANNEL_COUNT-1:0] ONE = CHANNEL_COUNT'(1);

  spi_state_t               state;
  logic [CH_W-1:0]          ch_q;
  logic [DATA_WIDTH-1:0]    sreg, sreg_nx;
  logic [BW-1:0]            bit_cnt;
  logic                     gap_ext, tick, accept, bad_ch, finish;
  logic [CHANNEL_COUNT-1:0] sel;

  assign accept  = cmdValid && cmdReady;
  assign bad_ch  = int'(cmdChannel) >= CHANNEL_COUNT;
  assign sel     = ONE << ch_q;
  assign sreg_nx = sreg << 1;
  // GAP is one cycle short of two half-periods so the accept cycle plus busy time is a whole command period.
  assign finish  = (state == GAP) && tick && (gap_ext || HALF_PERIOD == 1);

  afe_spi_tick #(.HALF_PERIOD(HALF_PERIOD)) u_tick (
    .clk   (sysClk),
    .rst   (sysReset),
    .run   (state != IDLE),
    .clear (accept),
    .skip  ((state == GAP) && !gap_ext),
    .tick  (tick)
  );

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      state       <= IDLE;
      ch_q        <= '0;
      sreg        <= '0;
      bit_cnt     <= '0;
      gap_ext     <= 1'b0;
      cmdReady    <= 1'b1;
      doneStrobe  <= 1'b0;
      badChannel  <= 1'b0;
      AFE_SPI_CLK <= '0;
      AFE_SPI_SDI <= '0;
      AFE_SPI_LE  <= '0;
    end else begin
      doneStrobe <= 1'b0;
      badChannel <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (bad_ch) begin
            badChannel <= 1'b1;
          end else begin
            state       <= SETUP;
            cmdReady    <= 1'b0;
            ch_q        <= cmdChannel;
            sreg        <= cmdData;
            bit_cnt     <= TOP_BIT;
            AFE_SPI_SDI <= cmdData[DATA_WIDTH-1] ? (ONE << cmdChannel) : '0;
          end
        end
        SETUP: if (tick) begin
          state       <= SHIFT_HI;
          AFE_SPI_CLK <= sel;
        end
        SHIFT_HI: if (tick) begin
          AFE_SPI_CLK <= '0;
          if (bit_cnt == '0) begin
            state       <= LE_SETUP;
            AFE_SPI_SDI <= '0;
          end else begin
            state       <= SHIFT_LO;
            bit_cnt     <= bit_cnt - 1'b1;
            sreg        <= sreg_nx;
            AFE_SPI_SDI <= sreg_nx[DATA_WIDTH-1] ? sel : '0;
          end
        end
        SHIFT_LO: if (tick) begin
          state       <= SHIFT_HI;
          AFE_SPI_CLK <= sel;
        end
        LE_SETUP: if (tick) begin
          state      <= LE_HIGH;
          AFE_SPI_LE <= sel;
        end
        LE_HIGH: if (tick) begin
          state      <= GAP;
          AFE_SPI_LE <= '0;
          gap_ext    <= 1'b0;
        end
        GAP: begin
          if (finish) begin
            state      <= IDLE;
            cmdReady   <= 1'b1;
            doneStrobe <= 1'b1;
            gap_ext    <= 1'b0;
          end else if (tick) begin
            gap_ext <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AFE_SPI_SHADOW_EN
  logic [DATA_WIDTH-1:0] word_q;

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      word_q     <= '0;
      shadowData <= '0;
    end else begin
      if (accept && !bad_ch) word_q <= cmdData;
      if (finish) shadowData[ch_q*DATA_WIDTH +: DATA_WIDTH] <= word_q;
    end
  end
`else
  // Without shadow storage the accepted word lives only in the shift register.
`endif

endmodule

// File: tb/tb_afe_spi_ctrl.sv
// Scoreboard bench for afe_spi_ctrl: randomized commands, pin-level word reconstruction, timing against the command period.
module tb_afe_spi_ctrl;

  localparam int DW  = 8;
  localparam int HP  = 4;
  localparam int LAT = (2 * DW + 4) * HP;

  typedef struct {
    logic       ch;
    logic [7:0] data;
    int         acc;
  } txn_t;

  logic       sysClk, sysReset;
  logic       cmdValid, cmdReady, doneStrobe, badChannel;
  logic       cmdChannel;
  logic [7:0] cmdData;
  logic [1:0] AFE_SPI_CLK, AFE_SPI_SDI, AFE_SPI_LE;

  logic       cmdValid3, cmdReady3, doneStrobe3, badChannel3;
  logic [1:0] cmdChannel3;
  logic [7:0] cmdData3;
  logic [2:0] AFE_SPI_CLK3, AFE_SPI_SDI3, AFE_SPI_LE3;

`ifdef AFE_SPI_SHADOW_EN
  logic [15:0] shadowData, shadow_m;
  logic [23:0] shadowData3;
`endif

  afe_spi_ctrl #(.CLK_RATE(100000000), .SPI_CLK_RATE(12500000), .DATA_WIDTH(8), .CHANNEL_COUNT(2)) dut (
    .sysClk(sysClk), .sysReset(sysReset), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdChannel(cmdChannel), .cmdData(cmdData), .doneStrobe(doneStrobe), .badChannel(badChannel),
    .AFE_SPI_CLK(AFE_SPI_CLK), .AFE_SPI_SDI(AFE_SPI_SDI), .AFE_SPI_LE(AFE_SPI_LE)
`ifdef AFE_SPI_SHADOW_EN
    , .shadowData(shadowData)
`endif
  );

  afe_spi_ctrl #(.CLK_RATE(100000000), .SPI_CLK_RATE(12500000), .DATA_WIDTH(8), .CHANNEL_COUNT(3)) dut3 (
    .sysClk(sysClk), .sysReset(sysReset), .cmdValid(cmdValid3), .cmdReady(cmdReady3),
    .cmdChannel(cmdChannel3), .cmdData(cmdData3), .doneStrobe(doneStrobe3), .badChannel(badChannel3),
    .AFE_SPI_CLK(AFE_SPI_CLK3), .AFE_SPI_SDI(AFE_SPI_SDI3), .AFE_SPI_LE(AFE_SPI_LE3)
`ifdef AFE_SPI_SHADOW_EN
    , .shadowData(shadowData3)
`endif
  );

  int   n_pass = 0, n_total = 0;
  int   cyc = 0;
  int   model_free = 0;
  int   done_seen = 0, rdy_err = 0, pins3_act = 0, done3 = 0;
  txn_t q[$];
  int   q3[$];

  logic [7:0] cap [2];
  int         edges [2];
  int         le_cnt [2];
  logic [1:0] prev_clk, act;

  task automatic chk(input string name, input longint act_v, input longint exp_v);
    n_total++;
    if (act_v == exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act_v, exp_v, cyc);
  endtask

  task automatic clear_caps();
    for (int c = 0; c < 2; c++) begin
      cap[c] = '0; edges[c] = 0; le_cnt[c] = 0;
    end
    act = '0;
  endtask

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;
  always @(posedge sysClk) cyc++;

  // Pin monitor and scoreboard for the two-channel instance.
  always @(negedge sysClk) begin
    txn_t e;
    if (sysReset) begin
      clear_caps();
      prev_clk = '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (AFE_SPI_CLK[c] && !prev_clk[c]) begin
          cap[c] = {cap[c][6:0], AFE_SPI_SDI[c]};
          edges[c]++;
        end
        if (AFE_SPI_LE[c]) le_cnt[c]++;
      end
      act = act | AFE_SPI_CLK | AFE_SPI_SDI | AFE_SPI_LE;
      prev_clk = AFE_SPI_CLK;
      if (q.size() > 0 && cyc > q[0].acc && cyc < q[0].acc + LAT && cmdReady) rdy_err++;
      if (badChannel) chk("spurious_bad", 1, 0);
      if (doneStrobe) begin
        done_seen++;
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("latency", cyc - e.acc, LAT);
          chk("word", cap[e.ch], e.data);
          chk("clk_edges", edges[e.ch], DW);
          chk("le_width", le_cnt[e.ch], HP);
          chk("quiet_other", act[~e.ch], 0);
          chk("ready_at_done", cmdReady, 1);
          chk("ready_low_busy", rdy_err, 0);
`ifdef AFE_SPI_SHADOW_EN
          shadow_m[e.ch*8 +: 8] = e.data;
          chk("shadow", shadowData, shadow_m);
`endif
        end
        rdy_err = 0;
        clear_caps();
      end
    end
  end

  always @(negedge sysClk) begin
    int a;
    if (!sysReset) begin
      if ((AFE_SPI_CLK3 | AFE_SPI_SDI3 | AFE_SPI_LE3) != '0) pins3_act++;
      if (doneStrobe3) done3++;
      if (badChannel3) begin
        if (q3.size() == 0) begin
          chk("unexpected_bad", 1, 0);
        end else begin
          a = q3.pop_front();
          chk("bad_cycle", cyc - a, 1);
          chk("bad_ready", cmdReady3, 1);
        end
      end
    end
  end

  task automatic send(input logic ch, input logic [7:0] d);
    int issue, exp_acc, waited;
    issue = cyc;
    cmdValid = 1'b1; cmdChannel = ch; cmdData = d;
    waited = 0;
    while (!cmdReady && waited < 3 * LAT) begin
      @(negedge sysClk);
      waited++;
    end
    exp_acc = (issue > model_free) ? issue : model_free;
    chk("accept_cycle", cyc, exp_acc);
    q.push_back('{ch, d, cyc});
    model_free = cyc + LAT;
    @(negedge sysClk);
    cmdValid = 1'b0; cmdData = 8'($urandom); cmdChannel = 1'($urandom);
  endtask

  task automatic junk(input int n);
    for (int i = 0; i < n; i++) begin
      if (cyc + 3 < model_free) begin
        cmdValid = 1'b1; cmdData = 8'($urandom); cmdChannel = 1'($urandom);
      end
      @(negedge sysClk);
      cmdValid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 3 * LAT) begin
      @(negedge sysClk);
      n++;
    end
    chk("drain", q.size(), 0);
    @(negedge sysClk);
  endtask

  initial begin
    int d_before, w;
    sysReset = 1'b1;
    cmdValid = 1'b0; cmdChannel = 1'b0; cmdData = '0;
    cmdValid3 = 1'b0; cmdChannel3 = '0; cmdData3 = '0;
`ifdef AFE_SPI_SHADOW_EN
    shadow_m = '0;
`endif
    repeat (3) @(negedge sysClk);
    #2 sysReset = 1'b0;
    @(negedge sysClk);
    chk("rst_ready", cmdReady, 1);
    chk("rst_done", doneStrobe, 0);
    chk("rst_bad", badChannel, 0);
    chk("rst_pins", {AFE_SPI_CLK, AFE_SPI_SDI, AFE_SPI_LE}, 0);
    chk("rst_ready3", cmdReady3, 1);
`ifdef AFE_SPI_SHADOW_EN
    chk("rst_shadow", shadowData, 0);
`endif

    send(1'b0, 8'hA5); drain();
    send(1'b1, 8'h3C); drain();
    send(1'b0, 8'h01); send(1'b0, 8'hFF); drain();

    // Reset in the middle of a shift, after the third serial clock rising edge.
    send(1'b0, 8'($urandom));
    w = 0;
    while (edges[0] < 3 && w < 3 * LAT) begin
      @(negedge sysClk);
      #2;
      w++;
    end
    sysReset = 1'b1;
    q.delete();
    model_free = 0;
`ifdef AFE_SPI_SHADOW_EN
    shadow_m = '0;
`endif
    #1;
    chk("midrst_pins", {AFE_SPI_CLK, AFE_SPI_SDI, AFE_SPI_LE}, 0);
    chk("midrst_done", doneStrobe, 0);
    @(negedge sysClk);
    #2 sysReset = 1'b0;
    @(negedge sysClk);
    chk("midrst_ready", cmdReady, 1);
`ifdef AFE_SPI_SHADOW_EN
    chk("midrst_shadow", shadowData, 0);
`endif
    d_before = done_seen;
    repeat (LAT + 10) @(negedge sysClk);
    chk("midrst_no_done", done_seen - d_before, 0);
    send(1'b0, 8'h55); drain();

    for (int k = 0; k < 12; k++) begin
      send(1'($urandom_range(0, 1)), 8'($urandom));
      if ($urandom_range(0, 1) == 1) junk($urandom_range(1, 6));
      repeat ($urandom_range(0, 3)) @(negedge sysClk);
    end
    drain();

    for (int k = 0; k < 3; k++) begin
      cmdValid3 = 1'b1; cmdChannel3 = 2'd3; cmdData3 = 8'($urandom);
      chk("bad_ready_pre", cmdReady3, 1);
      q3.push_back(cyc);
      @(negedge sysClk);
      cmdValid3 = 1'b0;
      repeat (k) @(negedge sysClk);
    end
    repeat (LAT) @(negedge sysClk);
    chk("bad_drain", q3.size(), 0);
    chk("bad_no_pins", pins3_act, 0);
    chk("bad_no_done", done3, 0);
`ifdef AFE_SPI_SHADOW_EN
    chk("bad_shadow", shadowData3, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
